// File: rtl/pixel_stream_feeder_pkg.sv
// Shared constants and types for the raster plotter pixel path: image geometry,
// the per-pixel decision record handed to the plotter, and the feeder FSM states.
package pixel_stream_feeder_pkg;

  localparam int IMG_W          = 80;
  localparam int IMG_H          = 106;
  localparam int STEPS_PER_CELL = 9;

  typedef struct packed {
    logic on;
    logic eol;
    logic last;
  } pix_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/pixel_stream_feeder_if.sv
// BRAM read port plus the pixel valid/ready channel towards the plotter FSM.
interface pixel_stream_feeder_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;
  logic              pix_valid;
  logic              pix_on;
  logic              pix_eol;
  logic              pix_last;
  logic              pix_ready;

  modport master (
    output mem_addr, mem_rd,
    input  mem_data,
    output pix_valid, pix_on, pix_eol, pix_last,
    input  pix_ready
  );

  modport slave (
    input  mem_addr, mem_rd,
    output mem_data,
    input  pix_valid, pix_on, pix_eol, pix_last,
    output pix_ready
  );
endinterface

// File: rtl/pixel_stream_feeder_fifo.sv
// Small synchronous FIFO of pixel decisions; a pop on an empty FIFO is ignored and
// a push into a full FIFO is only accepted together with a pop.
module pixel_fifo
  import pixel_stream_feeder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  pix_t                   i_din,
  input  logic                   i_pop,
  output pix_t                   o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  pix_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && o_full && !i_pop));
  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    r_count <= FULL_CNT);

endmodule

// File: rtl/pixel_stream_feeder.sv
// Walks a grayscale BRAM image in raster order, thresholds each pixel and feeds
// ink/no-ink decisions with line/image end tags to the plotter over valid/ready.
module pixel_stream_feeder
  import pixel_stream_feeder_pkg::*;
#(
  parameter int IMG_W      = pixel_stream_feeder_pkg::IMG_W,
  parameter int IMG_H      = pixel_stream_feeder_pkg::IMG_H,
  parameter int ADDR_W     = 14,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int THRESH     = 128
) (
  input  logic                 clk_100mhz,
  input  logic                 cpu_resetn,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  pixel_stream_feeder_if.master bus
);
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int INF_W = $clog2(RD_LATENCY + 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

  typedef struct packed {
    logic eol;
    logic last;
  } tag_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_W-1:0]     r_addr;
  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;
  logic [RD_LATENCY-1:0] r_vld_p;
  tag_t                  r_tag_p [RD_LATENCY];
  logic                  w_rd;
  logic                  w_last_rd;
  logic                  w_new_img;
  logic                  w_pop;
  logic                  w_credit;
  logic [INF_W-1:0]      w_inflight;
  logic [CNT_W-1:0]      w_fifo_count;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  pix_t                  w_push_pix;
  pix_t                  w_head;

  function automatic logic f_ink(input logic [7:0] gray);
    return int'(gray) < THRESH;
  endfunction

  function automatic logic [INF_W-1:0] f_popcount(input logic [RD_LATENCY-1:0] v);
    logic [INF_W-1:0] n;
    n = '0;
    for (int i = 0; i < RD_LATENCY; i++) n = n + INF_W'(v[i]);
    return n;
  endfunction

  // Reads already in the BRAM pipe hold a FIFO slot, so the FIFO can never overflow.
  assign w_inflight = f_popcount(r_vld_p);
  assign w_credit   = !w_fifo_full &&
                      ((int'(w_fifo_count) + int'(w_inflight)) < FIFO_DEPTH);
  assign w_rd       = (r_state == ST_FETCH) && w_credit;
  assign w_last_rd  = (r_row == ROW_MAX) && (r_col == COL_MAX);
  assign w_new_img  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_pop      = bus.pix_ready && !w_fifo_empty;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_FETCH;
      ST_FETCH: if (w_rd && w_last_rd) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_pop && w_head.last) w_state_nxt = ST_DONE;
      ST_DONE:  if (start) w_state_nxt = ST_FETCH;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge cpu_resetn) begin
    if (!cpu_resetn) r_state <= ST_IDLE;
    else             r_state <= w_state_nxt;
  end

  // Issue stage: running address plus row/col for tagging, no multiply needed.
  always_ff @(posedge clk_100mhz or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_addr <= '0;
      r_col  <= '0;
      r_row  <= '0;
    end else if (w_new_img || (w_rd && w_last_rd)) begin
      r_addr <= '0;
      r_col  <= '0;
      r_row  <= '0;
    end else if (w_rd) begin
      r_addr <= r_addr + ADDR_W'(1);
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // BRAM latency stages: valid bits are control, tags ride along unreset.
  always_ff @(posedge clk_100mhz or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[0] <= w_rd;
      for (int i = 1; i < RD_LATENCY; i++) r_vld_p[i] <= r_vld_p[i-1];
    end
  end

  always_ff @(posedge clk_100mhz) begin
    r_tag_p[0] <= '{eol: (r_col == COL_MAX), last: w_last_rd};
    for (int i = 1; i < RD_LATENCY; i++) r_tag_p[i] <= r_tag_p[i-1];
  end

  // Threshold stage: data and its tag meet at the FIFO input.
  always_comb begin
    w_push_pix      = '0;
    w_push_pix.on   = f_ink(bus.mem_data);
    w_push_pix.eol  = r_tag_p[RD_LATENCY-1].eol;
    w_push_pix.last = r_tag_p[RD_LATENCY-1].last;
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_100mhz),
    .rst_n   (cpu_resetn),
    .i_push  (r_vld_p[RD_LATENCY-1]),
    .i_din   (w_push_pix),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign bus.mem_addr  = r_addr;
  assign bus.mem_rd    = w_rd;
  assign bus.pix_valid = !w_fifo_empty;
  assign bus.pix_on    = w_head.on   && !w_fifo_empty;
  assign bus.pix_eol   = w_head.eol  && !w_fifo_empty;
  assign bus.pix_last  = w_head.last && !w_fifo_empty;
  assign busy          = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  assign done          = (r_state == ST_DONE);

endmodule

// File: tb/tb_pixel_stream_feeder.sv
// Bench for pixel_stream_feeder: a 4x2 instance for exact sequences and a full
// 80x106 instance for randomized back-pressure, both against an image-level model.
module tb_pixel_stream_feeder;
  localparam int SW = 4,  SH = 2,   SA = 3,  SN = SW * SH;
  localparam int FW = 80, FH = 106, FA = 14, FN = FW * FH;
  localparam int THR = 128;

  typedef struct {
    logic [7:0] data;
    logic [2:0] exp;   // {on, eol, last}
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic s_start = 1'b0, f_start = 1'b0;
  logic s_busy, s_done, f_busy, f_done;
  int   n_chk = 0, n_fail = 0, cyc = 0;

  pixel_stream_feeder_if #(.ADDR_W(SA)) s_if ();
  pixel_stream_feeder_if #(.ADDR_W(FA)) f_if ();

  pixel_stream_feeder #(
    .IMG_W(SW), .IMG_H(SH), .ADDR_W(SA), .RD_LATENCY(2), .FIFO_DEPTH(4), .THRESH(THR)
  ) dut_s (
    .clk_100mhz(clk), .cpu_resetn(rst_n), .start(s_start),
    .busy(s_busy), .done(s_done), .bus(s_if)
  );

  pixel_stream_feeder #(
    .IMG_W(FW), .IMG_H(FH), .ADDR_W(FA), .RD_LATENCY(2), .FIFO_DEPTH(4), .THRESH(THR)
  ) dut_f (
    .clk_100mhz(clk), .cpu_resetn(rst_n), .start(f_start),
    .busy(f_busy), .done(f_done), .bus(f_if)
  );

  always #5 clk = ~clk;

  // Two-cycle BRAM models; garbage when no read was issued
  logic [7:0] s_mem [SN];
  logic [7:0] f_mem [FN];
  logic [7:0] s_d1 = 8'hA5, s_d2 = 8'hA5, f_d1 = 8'hA5, f_d2 = 8'hA5;
  always @(posedge clk) begin
    s_d1 <= s_if.mem_rd ? s_mem[s_if.mem_addr] : 8'hA5;
    s_d2 <= s_d1;
    f_d1 <= f_if.mem_rd ? f_mem[f_if.mem_addr] : 8'hA5;
    f_d2 <= f_d1;
  end
  assign s_if.mem_data = s_d2;
  assign f_if.mem_data = f_d2;

  function automatic void check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endfunction

  function automatic logic [2:0] s_exp(input int k);
    return {s_mem[k] < THR, (k % SW) == SW - 1, k == SN - 1};
  endfunction

  function automatic logic [2:0] f_exp(input int k);
    return {f_mem[k] < THR, (k % FW) == FW - 1, k == FN - 1};
  endfunction

  int s_rd = 0, s_rx = 0, f_rd = 0, f_rx = 0;
  int s_first = -1, s_lastc = -1;
  logic [2:0] s_q [$];
  logic [2:0] f_q [$];
  logic [3:0] s_hold = '0, f_hold = '0;
  logic s_chk_done = 1'b0, f_chk_done = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      s_hold = '0;
      s_chk_done = 1'b0;
    end else begin
      if (s_chk_done) check("s_done_after_last", s_done, 1);
      s_chk_done = 1'b0;
      if (s_hold[3])
        check("s_head_stable", {s_if.pix_valid, s_if.pix_on, s_if.pix_eol, s_if.pix_last}, s_hold);
      if (s_if.mem_rd) begin
        check("s_addr", s_if.mem_addr, s_rd);
        s_rd++;
      end
      if (s_if.pix_valid && s_if.pix_ready) begin
        if (s_rx < SN) check($sformatf("s_pixel%0d", s_rx),
                             {s_if.pix_on, s_if.pix_eol, s_if.pix_last}, s_exp(s_rx));
        else check("s_extra_pixel", s_rx, SN - 1);
        check("s_done_low", s_done, 0);
        s_q.push_back({s_if.pix_on, s_if.pix_eol, s_if.pix_last});
        if (s_first < 0) s_first = cyc;
        s_lastc = cyc;
        if (s_if.pix_last) s_chk_done = 1'b1;
        s_rx++;
      end
      s_hold = (s_if.pix_valid && !s_if.pix_ready) ?
               {1'b1, s_if.pix_on, s_if.pix_eol, s_if.pix_last} : 4'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      f_hold = '0;
      f_chk_done = 1'b0;
    end else begin
      if (f_chk_done) check("f_done_after_last", f_done, 1);
      f_chk_done = 1'b0;
      if (f_hold[3])
        check("f_head_stable", {f_if.pix_valid, f_if.pix_on, f_if.pix_eol, f_if.pix_last}, f_hold);
      if (f_if.mem_rd) begin
        check("f_addr", f_if.mem_addr, f_rd);
        f_rd++;
      end
      if (f_if.pix_valid && f_if.pix_ready) begin
        if (f_rx < FN) check($sformatf("f_pixel%0d", f_rx),
                             {f_if.pix_on, f_if.pix_eol, f_if.pix_last}, f_exp(f_rx));
        else check("f_extra_pixel", f_rx, FN - 1);
        f_q.push_back({f_if.pix_on, f_if.pix_eol, f_if.pix_last});
        if (f_if.pix_last) f_chk_done = 1'b1;
        f_rx++;
      end
      f_hold = (f_if.pix_valid && !f_if.pix_ready) ?
               {1'b1, f_if.pix_on, f_if.pix_eol, f_if.pix_last} : 4'b0;
    end
  end

  // Plotter-side ready for the full-size instance: fixed or 30% random
  logic f_rand = 1'b0, f_rdy = 1'b0;
  initial begin
    f_if.pix_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      f_if.pix_ready = f_rand ? ($urandom_range(0, 99) < 30) : f_rdy;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_img(input bit full);
    if (full) begin
      f_rd = 0; f_rx = 0; f_q.delete(); f_start = 1'b1;
    end else begin
      s_rd = 0; s_rx = 0; s_q.delete(); s_first = -1; s_lastc = -1; s_start = 1'b1;
    end
    tick();
    s_start = 1'b0;
    f_start = 1'b0;
  endtask

  task automatic wait_done(input bit full, input int budget, input string name);
    int c = 0;
    while (!(full ? f_done : s_done) && c < budget) begin
      tick();
      c++;
    end
    check(name, full ? f_done : s_done, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_addr"}, f_if.mem_addr, 0);
    check({tag, "_mem_rd"},   f_if.mem_rd, 0);
    check({tag, "_valid"},    f_if.pix_valid, 0);
    check({tag, "_on"},       f_if.pix_on, 0);
    check({tag, "_eol"},      f_if.pix_eol, 0);
    check({tag, "_last"},     f_if.pix_last, 0);
    check({tag, "_busy"},     f_busy, 0);
    check({tag, "_done"},     f_done, 0);
  endtask

  initial begin
    vec_t t1 [SN];
    vec_t t4 [4];
    int   c;

    s_if.pix_ready = 1'b0;
    for (int i = 0; i < SN; i++) t1[i].data = 8'((i * 40) % 256);
    t1[0].exp = 3'b100; t1[1].exp = 3'b100; t1[2].exp = 3'b100; t1[3].exp = 3'b110;
    t1[4].exp = 3'b000; t1[5].exp = 3'b000; t1[6].exp = 3'b000; t1[7].exp = 3'b111;
    t4[0] = '{8'd127, 3'b100};
    t4[1] = '{8'd128, 3'b000};
    t4[2] = '{8'd0,   3'b100};
    t4[3] = '{8'd255, 3'b000};
    for (int i = 0; i < SN; i++) s_mem[i] = t1[i].data;
    for (int i = 0; i < FN; i++) f_mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++) f_mem[i] = t4[i].data;

    // Reset state
    #2 rst_n = 1'b0;
    tick(2);
    check_idle_outputs("rst");
    check("rst_s_valid", s_if.pix_valid, 0);
    check("rst_s_mem_rd", s_if.mem_rd, 0);
    check("rst_s_done", s_done, 0);
    rst_n = 1'b1;
    tick(2);

    // Small ramp image, plotter always ready
    s_if.pix_ready = 1'b1;
    start_img(0);
    check("t1_busy", s_busy, 1);
    wait_done(0, 50, "t1_done");
    check("t1_count", s_q.size(), SN);
    for (int i = 0; i < SN; i++) check($sformatf("t1_pix%0d", i), s_q[i], t1[i].exp);
    check("t1_throughput", s_lastc - s_first, SN - 1);
    check("t1_busy_end", s_busy, 0);

    // Plotter stalled: credit limit, stable head, then lossless drain
    s_if.pix_ready = 1'b0;
    start_img(0);
    tick(20);
    check("t2_reads", s_rd, 4);
    check("t2_rd_idle", s_if.mem_rd, 0);
    check("t2_valid", s_if.pix_valid, 1);
    check("t2_head", {s_if.pix_on, s_if.pix_eol, s_if.pix_last}, t1[0].exp);
    tick(10);
    check("t2_reads_hold", s_rd, 4);
    s_if.pix_ready = 1'b1;
    wait_done(0, 50, "t2_done");
    check("t2_count", s_q.size(), SN);
    for (int i = 0; i < SN; i++) check($sformatf("t2_pix%0d", i), s_q[i], t1[i].exp);

    // start during FETCH is ignored; start in DONE begins a new image
    start_img(0);
    tick(2);
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    wait_done(0, 50, "t6_done");
    check("t6_count", s_rx, SN);
    tick(3);
    check("t6_done_level", s_done, 1);
    start_img(0);
    check("t6_done_cleared", s_done, 0);
    check("t6_busy_again", s_busy, 1);
    wait_done(0, 50, "t6_done2");
    check("t6_count2", s_rx, SN);

    // Full-size image under 30% random ready
    f_rand = 1'b1;
    start_img(1);
    wait_done(1, 45000, "t3_done");
    check("t3_count", f_rx, FN);
    check("t3_qsize", f_q.size(), FN);
    for (int i = 0; i < 4; i++) check($sformatf("t4_pix%0d", i), f_q[i], t4[i].exp);
    f_rand = 1'b0;
    f_rdy  = 1'b1;
    tick(2);

    // Reset in the middle of row 1, then a clean restart from address 0
    start_img(1);
    c = 0;
    while (f_rd < FW + 2 && c < 1000) begin
      tick();
      c++;
    end
    check("t5_reached_row1", f_rd >= FW + 2, 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t5_rst");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("t5_idle_busy", f_busy, 0);
    start_img(1);
    wait_done(1, 20000, "t5_done");
    check("t5_count", f_rx, FN);
    for (int i = 0; i < 4; i++) check($sformatf("t5_pix%0d", i), f_q[i], t4[i].exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
